qos_tracker_aged: RTL and testbench

Parametrised successor of the outstanding-transaction QoS tracker. It holds one QoS entry per transaction ID: written on allocate, cleared on release. It reports the maximum QoS among outstanding IDs, which ID holds that maximum, and the outstanding count. New behaviours:
- optional age-based QoS promotion, so long-outstanding transactions escalate;
- protocol-error flags.
It sits beside the request arbiter and feeds the pending-priority signal upstream.

---
 rtl/qos_tracker_pkg.sv | 22 ++
 rtl/qos_argmax.sv | 40 ++++
 rtl/qos_tracker_aged.sv | 122 ++++++++++++
 tb/tb_qos_tracker_aged.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/qos_tracker_pkg.sv
// Shared types and default geometry for the aged QoS tracker.
// Modules take their own widths as parameters; these are the defaults.
package qos_tracker_pkg;

  localparam int unsigned IdWDefault   = 4;
  localparam int unsigned QosWDefault  = 3;
  localparam int unsigned AgeWDefault  = 8;
  localparam int unsigned AgeLimitDef  = 200;

  localparam int unsigned NUM_IDS = 2 ** IdWDefault;
  localparam int unsigned QOS_MAX = 2 ** QosWDefault - 1;

  typedef logic [QosWDefault-1:0] qos_t;
  typedef logic [IdWDefault-1:0]  id_t;

  typedef struct packed {
    logic                   vld;
    qos_t                   qos;
    logic [AgeWDefault-1:0] age;
  } entry_t;

endpackage

// File: rtl/qos_argmax.sv
// Combinational arg-max over valid QoS entries, balanced tree, lower index wins ties.
module qos_argmax #(
  parameter int unsigned ID_W  = 4,
  parameter int unsigned QOS_W = 3
) (
  input  logic [2**ID_W-1:0]       vld,
  input  logic [2**ID_W*QOS_W-1:0] qos,
  output logic                     any_vld,
  output logic [QOS_W-1:0]         max_qos,
  output logic [ID_W-1:0]          max_id
);

  localparam int unsigned NumIds = 2 ** ID_W;

  // Heap layout: node n combines children 2n (lower ids) and 2n+1; leaves at NumIds+i.
  logic             node_vld [1:2*NumIds-1];
  logic [QOS_W-1:0] node_qos [1:2*NumIds-1];
  logic [ID_W-1:0]  node_id  [1:2*NumIds-1];

  for (genvar i = 0; i < NumIds; i++) begin : g_leaf
    assign node_vld[NumIds+i] = vld[i];
    assign node_qos[NumIds+i] = vld[i] ? qos[i*QOS_W +: QOS_W] : '0;
    assign node_id[NumIds+i]  = ID_W'(i);
  end

  for (genvar n = 1; n < NumIds; n++) begin : g_node
    logic take_r;
    // Right side only wins on a strictly greater valid QoS.
    assign take_r = node_vld[2*n+1] &&
                    (!node_vld[2*n] || (node_qos[2*n+1] > node_qos[2*n]));
    assign node_vld[n] = node_vld[2*n] | node_vld[2*n+1];
    assign node_qos[n] = take_r ? node_qos[2*n+1] : node_qos[2*n];
    assign node_id[n]  = take_r ? node_id[2*n+1]  : node_id[2*n];
  end

  assign any_vld = node_vld[1];
  assign max_qos = node_qos[1];
  assign max_id  = node_id[1];

endmodule

// File: rtl/qos_tracker_aged.sv
// Per-ID QoS table for outstanding transactions with age promotion, registered
// max/argmax/count summary and protocol-error pulses.
module qos_tracker_aged
  import qos_tracker_pkg::*;
#(
  parameter int unsigned ID_W      = IdWDefault,
  parameter int unsigned QOS_W     = QosWDefault,
  parameter int unsigned AGE_EN    = 1,
  parameter int unsigned AGE_W     = AgeWDefault,
  parameter int unsigned AGE_LIMIT = AgeLimitDef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_vld,
  input  logic [ID_W-1:0]   wr_id,
  input  logic [QOS_W-1:0]  wr_qos,
  input  logic              rd_vld,
  input  logic [ID_W-1:0]   rd_id,
  output logic [QOS_W-1:0]  rd_qos,
  output logic              o_max_vld,
  output logic [QOS_W-1:0]  o_max_qos,
  output logic [ID_W-1:0]   o_max_id,
  output logic [ID_W:0]     o_outstanding,
  output logic              o_err_dup_wr,
  output logic              o_err_bad_rd
);

  localparam int unsigned      NumIds  = 2 ** ID_W;
  localparam logic [QOS_W-1:0] QosMax  = {QOS_W{1'b1}};
  localparam logic [AGE_W-1:0] AgeLast = AGE_W'(AGE_LIMIT - 1);

  logic [NumIds-1:0] vld_q, vld_d;
  logic [QOS_W-1:0]  qos_q [NumIds];
  logic [QOS_W-1:0]  qos_d [NumIds];
  logic [AGE_W-1:0]  age_q [NumIds];
  logic [AGE_W-1:0]  age_d [NumIds];

  logic [NumIds*QOS_W-1:0] qos_flat;
  logic                    any_vld;
  logic [QOS_W-1:0]        max_qos;
  logic [ID_W-1:0]         max_id;
  logic [ID_W:0]           count;
  logic                    dup_wr, bad_rd;

  // Table next state: write, then aging for untouched valid entries, then release wins.
  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      vld_d[i] = vld_q[i];
      qos_d[i] = qos_q[i];
      age_d[i] = '0;
      if (wr_vld && (wr_id == ID_W'(i))) begin
        vld_d[i] = 1'b1;
        qos_d[i] = wr_qos;
      end else if ((AGE_EN != 0) && vld_q[i] && (qos_q[i] != QosMax)) begin
        if (age_q[i] == AgeLast) begin
          qos_d[i] = qos_q[i] + 1'b1;
        end else begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
      if (rd_vld && (rd_id == ID_W'(i))) begin
        vld_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    qos_flat = '0;
    count    = '0;
    for (int i = 0; i < NumIds; i++) begin
      qos_flat[i*QOS_W +: QOS_W] = qos_q[i];
      count = count + (ID_W+1)'(vld_q[i]);
    end
  end

  always_comb begin
    dup_wr = wr_vld && vld_q[wr_id] && !(rd_vld && (rd_id == wr_id));
    bad_rd = rd_vld && !vld_q[rd_id];
  end

  qos_argmax #(
    .ID_W  (ID_W),
    .QOS_W (QOS_W)
  ) u_argmax (
    .vld     (vld_q),
    .qos     (qos_flat),
    .any_vld (any_vld),
    .max_qos (max_qos),
    .max_id  (max_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q         <= '0;
      o_max_vld     <= 1'b0;
      o_max_qos     <= '0;
      o_max_id      <= '0;
      o_outstanding <= '0;
      o_err_dup_wr  <= 1'b0;
      o_err_bad_rd  <= 1'b0;
      for (int i = 0; i < NumIds; i++) begin
        qos_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      vld_q         <= vld_d;
      o_max_vld     <= any_vld;
      o_max_qos     <= max_qos;
      o_max_id      <= max_id;
      o_outstanding <= count;
      o_err_dup_wr  <= dup_wr;
      o_err_bad_rd  <= bad_rd;
      for (int i = 0; i < NumIds; i++) begin
        qos_q[i] <= qos_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

  assign rd_qos = qos_q[rd_id];

endmodule

// File: tb/tb_qos_tracker_aged.sv
// Directed self-checking bench: main instance for table/summary/error behaviour,
// a second instance with a short age limit for promotion.
module tb_qos_tracker_aged;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       wr_vld = 1'b0;
  logic [3:0] wr_id  = '0;
  logic [2:0] wr_qos = '0;
  logic       rd_vld = 1'b0;
  logic [3:0] rd_id  = '0;
  logic [2:0] rd_qos;
  logic       max_vld;
  logic [2:0] max_qos;
  logic [3:0] max_id;
  logic [4:0] outstanding;
  logic       err_dup, err_bad;

  logic       a_wr_vld = 1'b0;
  logic [3:0] a_wr_id  = '0;
  logic [2:0] a_wr_qos = '0;
  logic       a_rd_vld = 1'b0;
  logic [3:0] a_rd_id  = '0;
  logic [2:0] a_rd_qos;
  logic       a_max_vld;
  logic [2:0] a_max_qos;
  logic [3:0] a_max_id;
  logic [4:0] a_outstanding;
  logic       a_err_dup, a_err_bad;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  qos_tracker_aged #(
    .ID_W(4), .QOS_W(3), .AGE_EN(1), .AGE_W(8), .AGE_LIMIT(200)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .wr_vld        (wr_vld),
    .wr_id         (wr_id),
    .wr_qos        (wr_qos),
    .rd_vld        (rd_vld),
    .rd_id         (rd_id),
    .rd_qos        (rd_qos),
    .o_max_vld     (max_vld),
    .o_max_qos     (max_qos),
    .o_max_id      (max_id),
    .o_outstanding (outstanding),
    .o_err_dup_wr  (err_dup),
    .o_err_bad_rd  (err_bad)
  );

  qos_tracker_aged #(
    .ID_W(4), .QOS_W(3), .AGE_EN(1), .AGE_W(8), .AGE_LIMIT(4)
  ) u_age (
    .clk           (clk),
    .rst           (rst),
    .wr_vld        (a_wr_vld),
    .wr_id         (a_wr_id),
    .wr_qos        (a_wr_qos),
    .rd_vld        (a_rd_vld),
    .rd_id         (a_rd_id),
    .rd_qos        (a_rd_qos),
    .o_max_vld     (a_max_vld),
    .o_max_qos     (a_max_qos),
    .o_max_id      (a_max_id),
    .o_outstanding (a_outstanding),
    .o_err_dup_wr  (a_err_dup),
    .o_err_bad_rd  (a_err_bad)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] id, input logic [2:0] q);
    wr_vld = 1'b1;
    wr_id  = id;
    wr_qos = q;
    tick();
    wr_vld = 1'b0;
  endtask

  task automatic release_id(input logic [3:0] id);
    rd_vld = 1'b1;
    rd_id  = id;
    tick();
    rd_vld = 1'b0;
  endtask

  task automatic check_summary(input string tag, input logic v, input logic [2:0] q,
                               input logic [3:0] id, input logic [4:0] n);
    check({tag, "_vld"}, max_vld, v);
    check({tag, "_qos"}, max_qos, q);
    check({tag, "_id"}, max_id, id);
    check({tag, "_cnt"}, outstanding, n);
  endtask

  initial begin
    // Reset
    tick();
    tick();
    rst = 1'b0;
    check_summary("reset", 1'b0, 3'd0, 4'd0, 5'd0);
    check("reset_dup", err_dup, 0);
    check("reset_bad", err_bad, 0);

    // Basic max / tie-break
    write(4'd3, 3'd2);
    write(4'd9, 3'd5);
    write(4'd12, 3'd5);
    tick();
    check_summary("three", 1'b1, 3'd5, 4'd9, 5'd3);

    // Release id9: table updates, summary follows one cycle later
    release_id(4'd9);
    check("rel9_lat_id", max_id, 9);
    tick();
    check_summary("rel9", 1'b1, 3'd5, 4'd12, 5'd2);
    rd_id = 4'd9;
    #1;
    check("rel9_rdqos", rd_qos, 5);
    release_id(4'd12);
    release_id(4'd3);
    tick();
    check_summary("empty", 1'b0, 3'd0, 4'd0, 5'd0);

    // Same-cycle write+release to same ID
    write(4'd5, 3'd1);
    tick();
    check("pre5_cnt", outstanding, 1);
    wr_vld = 1'b1; wr_id = 4'd5; wr_qos = 3'd4;
    rd_vld = 1'b1; rd_id = 4'd5;
    tick();
    wr_vld = 1'b0; rd_vld = 1'b0;
    check("same5_rdqos", rd_qos, 4);
    check("same5_dup", err_dup, 0);
    check("same5_bad", err_bad, 0);
    tick();
    check("same5_cnt", outstanding, 0);
    check("same5_vld", max_vld, 0);

    // Duplicate write and bad release
    write(4'd7, 3'd1);
    check("dup_first", err_dup, 0);
    write(4'd7, 3'd6);
    check("dup_pulse", err_dup, 1);
    tick();
    check("dup_clear", err_dup, 0);
    rd_id = 4'd7;
    #1;
    check("dup_rdqos", rd_qos, 6);
    release_id(4'd2);
    check("bad_pulse", err_bad, 1);
    tick();
    check("bad_clear", err_bad, 0);
    check("bad_cnt", outstanding, 1);
    check("bad_maxqos", max_qos, 6);

    // Age promotion on the short-limit instance
    a_wr_vld = 1'b1; a_wr_id = 4'd0; a_wr_qos = 3'd6; a_rd_id = 4'd0;
    tick();
    a_wr_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("age_hold", a_rd_qos, 6);
    end
    tick();
    check("age_promo", a_rd_qos, 7);
    check("age_max_lag", a_max_qos, 6);
    tick();
    check("age_max", a_max_qos, 7);
    repeat (20) tick();
    check("age_sat", a_rd_qos, 7);
    check("age_sat_max", a_max_qos, 7);
    check("age_cnt", a_outstanding, 1);

    // Fill all IDs, then reset mid-stream with a write pending
    for (int i = 0; i < 16; i++) write(4'(i), 3'(i % 8));
    tick();
    check_summary("full", 1'b1, 3'd7, 4'd7, 5'd16);
    wr_vld = 1'b1; wr_id = 4'd3; wr_qos = 3'd5; rd_id = 4'd3;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_vld = 1'b0;
    check_summary("midrst", 1'b0, 3'd0, 4'd0, 5'd0);
    check("midrst_rdqos", rd_qos, 0);
    check("midrst_dup", err_dup, 0);
    tick();
    check_summary("postrst", 1'b0, 3'd0, 4'd0, 5'd0);
    write(4'd3, 3'd2);
    write(4'd9, 3'd5);
    write(4'd12, 3'd5);
    tick();
    check_summary("again", 1'b1, 3'd5, 4'd9, 5'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
